// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_ext #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 5,
  parameter int AF_LEVEL = 2**AWIDTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] r_data,
  output logic [AWIDTH:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int              DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_nxt;
  logic              wr_ok;
  logic              rd_ok;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [AWIDTH-1:0] rd_ptr_nxt;
  logic [DWIDTH-1:0] head_nxt;

  // The next head may be the word being written this cycle, which mem does not hold yet.
  always_comb begin
    rd_ptr_nxt = rd_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
    head_nxt   = (wr_ok && (wr_ptr == rd_ptr_nxt)) ? w_data : mem[rd_ptr_nxt];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_ok) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      r_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
`ifdef SYNC_FIFO_FWFT_EN
      if (count_nxt != '0) r_data <= head_nxt;
`else
      if (rd_ok) r_data <= mem[rd_ptr];
`endif
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (wr && !wr_ok)    overflow <= 1'b1;
      else if (err_clr)    overflow <= 1'b0;
      if (rd && !rd_ok)    underflow <= 1'b1;
      else if (err_clr)    underflow <= 1'b0;
    end
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous FIFO, the next generation of the UART TX/RX buffer behind the AXI-Lite register interface. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also supports full-depth use, simultaneous read/write at any fill level, and a synchronous flush. An optional first-word-fall-through read mode is selectable at compile time.

## Interface
- DWIDTH, 8: data word width in bits.
- AWIDTH, 5: address width; depth is DEPTH = 2**AWIDTH entries, all usable.
- AF_LEVEL, 2**AWIDTH-4: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; does not clear error flags.
- wr  in  1  write request.
- w_data  in  DWIDTH  write data; sampled when a write is accepted.
- rd  in  1  read request (pop).
- r_data  out  DWIDTH  read data.
- count  out  AWIDTH+1  current occupancy, 0..DEPTH.
- empty, full  out  1 each  count==0 / count==DEPTH.
- almost_empty, almost_full  out  1 each  threshold flags.
- overflow, underflow  out  1 each  sticky error flags.
- err_clr  in  1  clears overflow and underflow.

## Operation
- State: wr_ptr and rd_ptr (each AWIDTH bits, wrapping naturally from DEPTH-1 to 0), count register, DEPTH x DWIDTH memory, r_data register.
- Write acceptance: wr_ok = wr & (~full | rd_ok).
- Read acceptance: rd_ok = rd & ~empty.
  - A write is therefore accepted when full if a read is accepted in the same cycle.
  - A read is never accepted when empty, including when wr is also high.
- Accepted write: mem[wr_ptr] <= w_data; wr_ptr <= wr_ptr+1.
- Accepted read: rd_ptr <= rd_ptr+1.
- count update: count <= count + wr_ok - rd_ok, computed at AWIDTH+1 bits. It never exceeds DEPTH or goes below 0.
- overflow sets on wr & ~wr_ok; underflow sets on rd & ~rd_ok. Both hold until err_clr or reset.
  - If err_clr coincides with a new error, the set wins.
- Rejected accesses leave the pointers, count, memory and r_data unchanged.
- flush: pointers and count go to 0 and r_data goes to 0. wr/rd in the flush cycle are ignored and do not raise error flags.
- reset: as flush, and additionally clears overflow/underflow.
  - Priority: reset > flush > err_clr/normal operation.
- Flags are combinational decodes of the count register: empty, full, almost_empty, almost_full.

## Timing
- Reset values: r_data=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Standard mode read latency: r_data <= mem[rd_ptr] at the edge where rd_ok=1. The word is valid from the next cycle and holds until the next accepted read.
- Flags and count reflect an access from the cycle after its clock edge.
- A write followed by a read of the same slot is valid with write-to-read spacing of one cycle: a word written at edge N is readable by rd at edge N+1, because empty has dropped after edge N.
- There is no combinational path from wr/rd to any output.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Undefined (default): standard mode as above, with one-cycle read latency and registered r_data.
- Defined: first-word-fall-through mode.
  - r_data always presents mem[rd_ptr] (the head word) whenever empty=0.
  - rd acknowledges and pops the head.
  - A word written at edge N appears on r_data after edge N, alongside empty=0.
  - While empty=1, r_data holds its last value, which is 0 after reset/flush.
  - Acceptance rules, count, flags and errors are identical to standard mode.

## Test plan
- Fill and drain (DWIDTH=8, AWIDTH=3):
  - Write 0x01..0x08: count=8, full=1, almost_full=1.
  - Read 8: r_data sequence 0x01..0x08, empty=1, no error flags.
- Overflow and underflow:
  - When full, wr with 0xAA: overflow=1, count stays 8, later reads never return 0xAA.
  - When empty, rd: underflow=1.
  - err_clr: both flags return to 0.
- Simultaneous access at full: rd+wr(0x55) gives count stays 8, r_data=oldest word, and 0x55 is read last after 7 more pops.
- Simultaneous access at empty: rd+wr(0x33) gives underflow=1, count=1, and a subsequent rd returns 0x33.
- Wrap-around and thresholds (AF_LEVEL=6, AE_LEVEL=2):
  - 20 interleaved write/read bursts keep data in order.
  - almost_full toggles exactly at count 6/5; almost_empty toggles exactly at count 2/3.
- Flush and reset mid-operation:
  - At count=5 with overflow=1, flush gives count=0, empty=1, r_data=0, overflow still 1.
  - reset additionally clears overflow.
  - With SYNC_FIFO_FWFT_EN, after one write of 0x77, r_data=0x77 in the next cycle without rd.
